// File: rtl/md_alu.sv
// md_alu: execute-stage ALU plus multi-cycle multiply/divide unit owning HI/LO.
// Result is purely combinational. mult/div results are computed at issue into
// holding registers and committed to hi/lo when the busy countdown expires.
// Optional build macro: MD_ALU_OVERFLOW_EN adds the signed add/sub overflow output.
module md_alu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Result,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
`ifdef MD_ALU_OVERFLOW_EN
  output logic [WIDTH-1:0] lo,
  output logic             overflow
`else
  output logic [WIDTH-1:0] lo
`endif
);

  localparam int SAW  = $clog2(WIDTH);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [SAW-1:0]   sa;
  logic [WIDTH-1:0] sum, diff;

  assign sa   = A[SAW-1:0];
  assign sum  = A + B;
  assign diff = A - B;

  // Combinational ALU result selection
  always_comb begin
    Result = '0;
    case (ALUop)
      4'b0000: Result = sum;
      4'b0001: Result = diff;
      4'b0010: Result = A | B;
      4'b0011: Result = A & B;
      4'b0100: Result = A ^ B;
      4'b0101: Result = ~(A | B);
      4'b0110: Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0111: Result = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1000: Result = B << sa;
      4'b1001: Result = B >> sa;
      4'b1010: Result = WIDTH'($signed(B) >>> sa);
      4'b1011: Result = B << (WIDTH / 2);
      default: Result = '0;
    endcase
  end

`ifdef MD_ALU_OVERFLOW_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // wrapped result's sign differs from A
  always_comb begin
    overflow = 1'b0;
    if (ALUop == 4'b0000)
      overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (ALUop == 4'b0001)
      overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  // Full-width products; sign extension to 2*WIDTH makes the low 2*WIDTH bits
  // of the unsigned product equal the signed product
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed divide on magnitudes; quotient sign is A^B, remainder follows A.
  // MIN/-1 falls out naturally: magnitude 2^(W-1) negates back to MIN, rem 0.
  // Divisors of zero are replaced by 1 only to keep the datapath defined; the
  // result is never committed in that case.
  logic [WIDTH-1:0] a_mag, b_mag, bs_safe, bu_safe;
  logic [WIDTH-1:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
  always_comb begin
    a_mag   = A[WIDTH-1] ? -A : A;
    b_mag   = B[WIDTH-1] ? -B : B;
    bs_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
    bu_safe = (B == '0) ? WIDTH'(1) : B;
    qs_mag  = a_mag / bs_safe;
    rs_mag  = a_mag % bs_safe;
    q_s     = (A[WIDTH-1] ^ B[WIDTH-1]) ? -qs_mag : qs_mag;
    r_s     = A[WIDTH-1] ? -rs_mag : rs_mag;
    q_u     = A / bu_safe;
    r_u     = A % bu_safe;
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rhi_q, rhi_d, rlo_q, rlo_d;
  logic             wr_q, wr_d;

  // Issue / countdown / commit control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT: begin
              {rhi_d, rlo_d} = prod_s;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            MD_MULTU: begin
              {rhi_d, rlo_d} = prod_u;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            MD_DIV: begin
              rhi_d   = r_s;
              rlo_d   = q_s;
              wr_d    = (B != '0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            MD_DIVU: begin
              rhi_d   = r_u;
              rlo_d   = q_u;
              wr_d    = (B != '0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (wr_q) begin
            hi_d = rhi_q;
            lo_d = rlo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      wr_q    <= wr_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
